// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_ctrl
//  Purpose  : Bit-serial WIDTH-bit subtractor controller, diff = a - b, LSB
//             first, one bit per clock through a single 1-bit subtract cell.
//  Option   : SERIAL_SUB_OVF_EN adds the signed overflow output ovf.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_sr;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               w_d;
    logic               w_bnext;
    logic               w_last;

    // Shared 1-bit subtract cell: two half-subtractors on the current LSBs.
    assign w_d     = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_bnext = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    assign w_last  = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_next_state = c_ST_RUN;
            c_ST_RUN:  if (w_last) w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_ST_RUN);
        done = (r_state == c_ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_sr     <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (r_state == c_ST_IDLE) begin
            if (start) begin
                r_sa  <= a;
                r_sb  <= b;
                r_br  <= 1'b0;
                r_cnt <= '0;
            end
        end else if (r_state == c_ST_RUN) begin
            r_sr  <= {w_d, r_sr[WIDTH-1:1]};
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_br  <= w_bnext;
            r_cnt <= r_cnt + c_CNT_W'(1);
            // Final bit is merged straight into the result, no extra cycle.
            if (w_last) begin
                r_diff   <= {w_d, r_sr[WIDTH-1:1]};
                r_borrow <= w_bnext;
            end
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow;

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // On the last bit sa[0]/sb[0] still hold the original operand MSBs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == c_ST_RUN) && w_last) begin
            r_ovf <= (r_sa[0] != r_sb[0]) && (w_d != r_sa[0]);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire
